// File: rtl/exp3_unidade_controle_if.sv
// Control bus between the exp3 control unit and its datapath
// (address counter, 16x4 ROM, switch register, 4-bit comparator).
// master: the control unit; slave: the datapath.
interface exp3_unidade_controle_if;
  logic zeraC;
  logic contaC;
  logic zeraR;
  logic registraR;
  logic fimC;
  logic chavesIgualMemoria;

  modport master (
    output zeraC,
    output contaC,
    output zeraR,
    output registraR,
    input  fimC,
    input  chavesIgualMemoria
  );

  modport slave (
    input  zeraC,
    input  contaC,
    input  zeraR,
    input  registraR,
    output fimC,
    output chavesIgualMemoria
  );
endinterface

// File: rtl/exp3_unidade_controle.sv
// exp3 control unit: Moore FSM that walks the 16 ROM positions, registering
// one switch play per position and ending in acerto (all 16 match) or erro
// (first mismatch). Every output is a pure decode of the state register.
// Optional build macro EXP3_TIMEOUT_EN adds a play timeout in ESPERA
// (TIMEOUT_CYCLES cycles) leading to FIM_TIMEOUT and the extra timeout port.
module exp3_unidade_controle
`ifdef EXP3_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 5000)
`endif
  (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          iniciar,
  input  logic                          jogada,
  exp3_unidade_controle_if.master       dp,
  output logic                          pronto,
  output logic                          acertou,
  output logic                          errou,
`ifdef EXP3_TIMEOUT_EN
  output logic                          timeout,
`endif
  output logic [3:0]                    db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
`ifdef EXP3_TIMEOUT_EN
    FIM_TIMEOUT = 4'hD,
`endif
    FIM_ERRO    = 4'hE
  } state_t;

  state_t state;
  state_t next_state;
  logic   jogada_d;
  logic   jogada_ev;

  assign jogada_ev = jogada & ~jogada_d;

`ifdef EXP3_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] espera_cnt;
  logic             expirou;

  assign expirou = (espera_cnt == LIMIT);

  // Counts ESPERA cycles; held at zero elsewhere so each ESPERA entry starts fresh
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      espera_cnt <= '0;
    else if (state != ESPERA)
      espera_cnt <= '0;
    else
      espera_cnt <= espera_cnt + 1'b1;
  end
`endif

  // Delayed copy of the play button for rising-edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      jogada_d <= 1'b0;
    else
      jogada_d <= jogada;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= INICIAL;
    else
      state <= next_state;
  end

  // Next-state logic; a mismatch takes priority over the terminal count
  always_comb begin
    next_state = INICIAL;
    case (state)
      INICIAL:    next_state = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: next_state = ESPERA;
`ifdef EXP3_TIMEOUT_EN
      ESPERA:     next_state = jogada_ev ? REGISTRA : (expirou ? FIM_TIMEOUT : ESPERA);
      FIM_TIMEOUT: next_state = iniciar ? PREPARACAO : FIM_TIMEOUT;
`else
      ESPERA:     next_state = jogada_ev ? REGISTRA : ESPERA;
`endif
      REGISTRA:   next_state = COMPARACAO;
      COMPARACAO: begin
        if (!dp.chavesIgualMemoria)
          next_state = FIM_ERRO;
        else if (dp.fimC)
          next_state = FIM_ACERTO;
        else
          next_state = PROXIMO;
      end
      PROXIMO:    next_state = ESPERA;
      FIM_ACERTO: next_state = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:   next_state = iniciar ? PREPARACAO : FIM_ERRO;
      default:    next_state = INICIAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    dp.zeraC     = 1'b0;
    dp.contaC    = 1'b0;
    dp.zeraR     = 1'b0;
    dp.registraR = 1'b0;
    pronto       = 1'b0;
    acertou      = 1'b0;
    errou        = 1'b0;
`ifdef EXP3_TIMEOUT_EN
    timeout      = 1'b0;
`endif
    case (state)
      INICIAL, PREPARACAO: begin
        dp.zeraC = 1'b1;
        dp.zeraR = 1'b1;
      end
      REGISTRA: dp.registraR = 1'b1;
      PROXIMO:  dp.contaC    = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
`ifdef EXP3_TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign db_estado = state;

endmodule
